data_ram_ctrl: RTL and testbench

//  Next-generation data RAM for the core's load/store path. Word-organised, byte-lane memory behind a

---
 rtl/data_ram_ctrl_if.sv | 27 ++
 rtl/data_ram_ctrl.sv | 154 +++++++++++++++
 tb/tb_data_ram_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between a load/store unit and data_ram_ctrl.
//   req_valid/req_ready : request handshake
//   req_we, req_access  : store flag and access size/extension code
//   req_addr, req_wdata : byte address and LSB-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata, rsp_err  : load result and rejection flag
interface data_ram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_access;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_access, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_access, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram_ctrl.sv
// Word-organised byte-lane data RAM with valid/ready request port and a
// 1-cycle registered response. Clears itself after reset with a sweep FSM.
//   clk, rst_n : clock, async active-low reset
//   bus        : data_ram_ctrl_if.slave request/response port
//   busy       : clear sweep in progress
module data_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  data_ram_ctrl_if.slave  bus,
  output logic            busy
);
  localparam int unsigned IDX_W = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IDX_W;

  localparam logic [2:0] ACC_B  = 3'b000;
  localparam logic [2:0] ACC_H  = 3'b001;
  localparam logic [2:0] ACC_W  = 3'b010;
  localparam logic [2:0] ACC_BU = 3'b100;
  localparam logic [2:0] ACC_HU = 3'b101;

  typedef enum logic {CLEAR, RUN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               clr_we;

  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic [IDX_W-1:0]   idx;
  logic [1:0]         lane;
  logic               oor, misaligned, illegal, err_c;
  logic [3:0]         be;
  logic [31:0]        wdata_lane;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        rd_ext;

  logic               ready_q, busy_q, rsp_valid_q, rsp_err_q;
  logic [31:0]        rsp_rdata_q;

  // State and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: sweep one word per cycle, leave CLEAR after the last word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Request decode, error checks, lane steering and load extension
  always_comb begin
    accept     = bus.req_valid & ready_q;
    idx        = bus.req_addr[ADDR_WIDTH-1:2];
    lane       = bus.req_addr[1:0];
    oor        = |(bus.req_addr >> ADDR_WIDTH);
    misaligned = 1'b0;
    illegal    = 1'b0;
    be         = 4'b0000;
    wdata_lane = bus.req_wdata;
    case (bus.req_access)
      ACC_B: begin
        be         = 4'b0001 << lane;
        wdata_lane = {4{bus.req_wdata[7:0]}};
      end
      ACC_H: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{bus.req_wdata[15:0]}};
      end
      ACC_W: begin
        misaligned = |lane;
        be         = 4'b1111;
      end
      ACC_BU:  illegal = bus.req_we;
      ACC_HU: begin
        misaligned = lane[0];
        illegal    = bus.req_we;
      end
      default: illegal = 1'b1;
    endcase
    err_c = oor | misaligned | illegal;

    rd_word = mem[idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.req_access)
      ACC_B:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      ACC_BU:  rd_ext = {24'h000000, rd_byte};
      ACC_H:   rd_ext = {{16{rd_half[15]}}, rd_half};
      ACC_HU:  rd_ext = {16'h0000, rd_half};
      ACC_W:   rd_ext = rd_word;
      default: rd_ext = 32'h0;
    endcase
  end

  // Memory array: not reset; cleared by the sweep, written by stores
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && bus.req_we && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

  // Registered outputs; response data holds while no response is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      busy_q      <= CLEAR_ON_RESET;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      ready_q     <= (state_d == RUN);
      busy_q      <= (state_d == CLEAR);
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q   <= err_c;
        rsp_rdata_q <= (err_c || bus.req_we) ? 32'h0 : rd_ext;
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl with a response scoreboard.
module tb_data_ram_ctrl;
  logic clk;
  logic rst_n;
  logic busy;

  data_ram_ctrl_if bus();

  data_ram_ctrl #(.ADDR_WIDTH(11), .CLEAR_ON_RESET(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  // Drive one request at a negedge; check its response one cycle later
  task automatic issue(input logic we, input logic [2:0] acc, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic exp_err,
                       input logic [31:0] exp_rdata, input string name);
    exp_t e;
    exp_t got;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, bus.req_ready);
    end
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_access = acc;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    q.push_back(e);
    @(negedge clk);
    got = q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_valid: got %b want 1", name, bus.rsp_valid);
    end else begin
      checks++;
      if ({bus.rsp_err, bus.rsp_rdata} !== {got.err, got.rdata}) begin
        errors++;
        $display("FAIL %s rsp: got err=%b rdata=%h want err=%b rdata=%h",
                 name, bus.rsp_err, bus.rsp_rdata, got.err, got.rdata);
      end
    end
  endtask

  task automatic idle(input string name);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle rsp_valid: got %b want 0", name, bus.rsp_valid);
    end
  endtask

  // Count busy cycles from the release negedge until busy drops
  task automatic sweep_count(input string name);
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 2000) begin
      if (bus.req_ready !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 512) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want 512", name, n);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s ready during sweep: got 1 want 0", name);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after sweep: got ready=%b busy=%b want ready=1 busy=0",
               name, bus.req_ready, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, bus.rsp_rdata} !== {4'b0001, 32'h0}) begin
      errors++;
      $display("FAIL reset outputs: got ready=%b vld=%b err=%b busy=%b rdata=%h want 0 0 0 1 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, bus.rsp_rdata);
    end
  endtask

  task automatic test_sweep();
    rst_n = 1'b1;
    sweep_count("sweep");
    issue(1'b0, W, 32'h7FC, 32'h0, 1'b0, 32'h0, "lw_7fc_cleared");
    idle("sweep");
  endtask

  task automatic test_byte();
    issue(1'b1, W,  32'h10, 32'h80FF7F01, 1'b0, 32'h0, "sw_10");
    issue(1'b0, B,  32'h10, 32'h0, 1'b0, 32'h00000001, "lb_10");
    issue(1'b0, B,  32'h11, 32'h0, 1'b0, 32'h0000007F, "lb_11");
    issue(1'b0, B,  32'h12, 32'h0, 1'b0, 32'hFFFFFFFF, "lb_12");
    issue(1'b0, B,  32'h13, 32'h0, 1'b0, 32'hFFFFFF80, "lb_13");
    issue(1'b0, BU, 32'h13, 32'h0, 1'b0, 32'h00000080, "lbu_13");
    issue(1'b1, B,  32'h12, 32'h000000AB, 1'b0, 32'h0, "sb_12");
    issue(1'b0, W,  32'h10, 32'h0, 1'b0, 32'h80AB7F01, "lw_10_after_sb");
    idle("byte");
  endtask

  task automatic test_half();
    issue(1'b1, W,  32'h20, 32'h11223344, 1'b0, 32'h0, "sw_20");
    issue(1'b1, H,  32'h22, 32'h0000BEEF, 1'b0, 32'h0, "sh_22");
    issue(1'b0, W,  32'h20, 32'h0, 1'b0, 32'hBEEF3344, "lw_20");
    issue(1'b0, H,  32'h22, 32'h0, 1'b0, 32'hFFFFBEEF, "lh_22");
    issue(1'b0, HU, 32'h22, 32'h0, 1'b0, 32'h0000BEEF, "lhu_22");
    issue(1'b0, H,  32'h20, 32'h0, 1'b0, 32'h00003344, "lh_20");
    idle("half");
  endtask

  task automatic test_errors();
    issue(1'b0, W,      32'h21,  32'h0, 1'b1, 32'h0, "err_lw_21");
    issue(1'b1, H,      32'h03,  32'hFFFF, 1'b1, 32'h0, "err_sh_03");
    issue(1'b1, W,      32'h800, 32'hDEADBEEF, 1'b1, 32'h0, "err_sw_800");
    issue(1'b0, 3'b011, 32'h20,  32'h0, 1'b1, 32'h0, "err_acc_011");
    issue(1'b1, BU,     32'h20,  32'h000000FF, 1'b1, 32'h0, "err_sbu_20");
    issue(1'b0, W,      32'h20,  32'h0, 1'b0, 32'hBEEF3344, "lw_20_unchanged");
    issue(1'b0, W,      32'h00,  32'h0, 1'b0, 32'h0, "lw_00_unchanged");
    idle("errors");
  endtask

  task automatic test_back_to_back();
    issue(1'b1, W, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0, "b2b_sw_40");
    issue(1'b0, W, 32'h40, 32'h0, 1'b0, 32'hA5A5A5A5, "b2b_lw_40");
    idle("b2b");
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b001) begin
      errors++;
      $display("FAIL mid_sweep_reset: got ready=%b vld=%b busy=%b want 0 0 1",
               bus.req_ready, bus.rsp_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep_count("resweep");
    issue(1'b0, W, 32'h40, 32'h0, 1'b0, 32'h0, "lw_40_recleared");
    bus.req_valid = 1'b0;
    @(negedge clk);
    // Accept a load, then drop reset in the following cycle
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_access = W;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL dropped_rsp: got rsp_valid=%b want 0", bus.rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sweep_count("post_drop");
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard residue: got %0d want 0", q.size());
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_access = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_sweep();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
